// File: rtl/fetch_decode_buffer_pkg.sv
// Shared IF/ID types and constants: instruction width, the NOP word and the
// fetch entry record that the IF/ID and ID/EX registers both carry.
package fetch_decode_buffer_pkg;

   localparam int          INSTR_W  = 32;
   localparam int          ENTRY_W  = 2 * INSTR_W;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [INSTR_W-1:0] pc4;
   } fetch_entry_t;

   function automatic fetch_entry_t make_entry(
      input logic [INSTR_W-1:0] instr,
      input logic [INSTR_W-1:0] pc4
   );
      fetch_entry_t e;
      e.instr = instr;
      e.pc4   = pc4;
      return e;
   endfunction

   function automatic fetch_entry_t empty_entry();
      fetch_entry_t e;
      e.instr = {INSTR_W{1'b0}};
      e.pc4   = {INSTR_W{1'b0}};
      return e;
   endfunction

endpackage

// File: rtl/fetch_decode_buffer_ring_store.sv
// Entry storage for the fetch/decode buffer: synchronous write and clear,
// asynchronous read of the entry selected by the read pointer.
module ring_store
   import fetch_decode_buffer_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               wr_en,
   input  logic [PTR_W-1:0]   wr_ptr,
   input  fetch_entry_t       wr_data,
   input  logic [PTR_W-1:0]   rd_ptr,
   output fetch_entry_t       rd_data
);

   fetch_entry_t mem_r [DEPTH];

   // Clear wins over a write in the same cycle.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= empty_entry();
         end
      end else if (wr_en) begin
         mem_r[wr_ptr] <= wr_data;
      end else begin
         mem_r[wr_ptr] <= mem_r[wr_ptr];
      end
   end

   // Head entry read.
   always_comb begin
      rd_data = mem_r[rd_ptr];
   end

endmodule

// File: rtl/fetch_decode_buffer.sv
// IF/ID decoupling FIFO: holds up to DEPTH {instruction, pc+4} entries,
// one-cycle latency, flushed on a taken branch or jump.
module fetch_decode_buffer
   import fetch_decode_buffer_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter int          PTR_W    = 1,
   parameter logic [31:0] NOP_WORD = fetch_decode_buffer_pkg::NOP_WORD
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [31:0]      Instruction,
   input  logic [31:0]      NextInstruct,
   input  logic             Flush,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [31:0]      OutInstruction,
   output logic [31:0]      OutNextInstruct,
   output logic [PTR_W:0]   Count
);

   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   ZERO_C  = (PTR_W+1)'(0);
   localparam logic [PTR_W:0]   ONE_C   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W:0]   count_r;
   logic [PTR_W:0]   count_next_s;
   logic             in_ready_s;
   logic             out_valid_s;
   logic             push_s;
   logic             pop_s;
   fetch_entry_t     wr_entry_s;
   fetch_entry_t     head_s;

   // Handshake qualification; a flush discards both sides of the handshake.
   always_comb begin
      in_ready_s  = (count_r != DEPTH_C);
      out_valid_s = (count_r != ZERO_C);
      push_s      = InValid & in_ready_s & ~Flush;
      pop_s       = out_valid_s & OutReady & ~Flush;
      wr_entry_s  = make_entry(Instruction, NextInstruct);
   end

   // Occupancy next value for the normal push/pop case.
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + ONE_C;
         2'b01:   count_next_s = count_r - ONE_C;
         default: count_next_s = count_r;
      endcase
   end

   // Pointer and occupancy state; Reset > Flush > push/pop.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_ptr_r <= PTR_ZERO;
         wr_ptr_r <= PTR_ZERO;
         count_r  <= ZERO_C;
      end else if (Flush) begin
         rd_ptr_r <= wr_ptr_r;
         wr_ptr_r <= wr_ptr_r;
         count_r  <= ZERO_C;
      end else begin
         rd_ptr_r <= pop_s  ? rd_ptr_r + PTR_ONE : rd_ptr_r;
         wr_ptr_r <= push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
         count_r  <= count_next_s;
      end
   end

   ring_store #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_store (
      .clk     (Clk),
      .clear   (Reset),
      .wr_en   (push_s),
      .wr_ptr  (wr_ptr_r),
      .wr_data (wr_entry_s),
      .rd_ptr  (rd_ptr_r),
      .rd_data (head_s)
   );

   // Outputs come straight from registered state; empty shows NOP / 0.
   always_comb begin
      InReady  = in_ready_s;
      OutValid = out_valid_s;
      Count    = count_r;
      if (out_valid_s) begin
         OutInstruction  = head_s.instr;
         OutNextInstruct = head_s.pc4;
      end else begin
         OutInstruction  = NOP_WORD;
         OutNextInstruct = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_fetch_decode_buffer;
   import fetch_decode_buffer_pkg::*;

   localparam int DEPTH = 2;
   localparam int PTR_W = 1;

   logic             Clk;
   logic             Reset;
   logic             InValid;
   logic             InReady;
   logic [31:0]      Instruction;
   logic [31:0]      NextInstruct;
   logic             Flush;
   logic             OutValid;
   logic             OutReady;
   logic [31:0]      OutInstruction;
   logic [31:0]      OutNextInstruct;
   logic [PTR_W:0]   Count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] model_q [$];

   fetch_decode_buffer #(
      .DEPTH    (DEPTH),
      .PTR_W    (PTR_W),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .InValid         (InValid),
      .InReady         (InReady),
      .Instruction     (Instruction),
      .NextInstruct    (NextInstruct),
      .Flush           (Flush),
      .OutValid        (OutValid),
      .OutReady        (OutReady),
      .OutInstruction  (OutInstruction),
      .OutNextInstruct (OutNextInstruct),
      .Count           (Count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive, compare outputs mid-cycle, advance model, clock.
   task automatic cyc(input logic rst, input logic iv, input logic [31:0] ins,
                      input logic [31:0] pc4, input logic fl, input logic ordy,
                      input bit chk);
      int sz;
      Reset = rst; InValid = iv; Instruction = ins; NextInstruct = pc4;
      Flush = fl; OutReady = ordy;
      #4;
      sz = model_q.size();
      if (chk) begin
         check_eq("out_valid", 64'(OutValid), 64'(sz != 0));
         check_eq("in_ready",  64'(InReady),  64'(sz != DEPTH));
         check_eq("count",     64'(Count),    64'(sz));
         check_eq("out_instr", 64'(OutInstruction),  (sz != 0) ? 64'(model_q[0][63:32]) : 64'h0);
         check_eq("out_pc4",   64'(OutNextInstruct), (sz != 0) ? 64'(model_q[0][31:0])  : 64'h0);
      end
      if (rst || fl) begin
         model_q.delete();
      end else begin
         if (ordy && sz > 0) void'(model_q.pop_front());
         if (iv && sz < DEPTH) model_q.push_back({ins, pc4});
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1; InValid = 1'b0; Instruction = 32'h0; NextInstruct = 32'h0;
      Flush = 1'b0; OutReady = 1'b0;

      // Reset, then idle
      cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

      // Fill to DEPTH while decode stalls, then drain
      cyc(1'b0, 1'b1, 32'h2008_0005, 32'h0000_0004, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'h2129_0001, 32'h0000_0008, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'hBAD0_0001, 32'h0000_000C, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

      // Streaming with decode always ready
      for (int i = 1; i <= 8; i++)
         cyc(1'b0, 1'b1, 32'(i), 32'(4 * i), 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

      // Flush while full, with a push in the same cycle
      cyc(1'b0, 1'b1, 32'h0000_0AAA, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'h0000_0BBB, 32'h0000_0104, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'h0000_DEAD, 32'h0000_0108, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 32'h0800_0010, 32'h0000_0044, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

      // Pointer wrap: alternate full and empty
      for (int r = 0; r < 5; r++) begin
         cyc(1'b0, 1'b1, 32'h1000_0000 + 32'(2 * r),     32'(8 * r),     1'b0, 1'b0, 1'b1);
         cyc(1'b0, 1'b1, 32'h1000_0000 + 32'(2 * r + 1), 32'(8 * r + 4), 1'b0, 1'b0, 1'b1);
         cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
         cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      end

      // Reset mid-operation together with Flush and a push
      cyc(1'b0, 1'b1, 32'h0000_0777, 32'h0000_0200, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 32'h0000_0888, 32'h0000_0204, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
             $urandom(), $urandom(),
             ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
             1'b1);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Decoupling buffer between the instruction fetch unit and the decode stage (the IF/ID boundary).
- Captures each fetched instruction together with its PC+4 value.
- Holds up to DEPTH entries so a decode stall does not immediately stall fetch.
- Flushes all held entries when a taken branch or jump redirects the PC.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, >= 2.
- PTR_W, 1, pointer width, equal to log2(DEPTH).
- NOP_WORD, 32'h00000000, instruction value presented when the buffer is empty.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  fetch presents a valid instruction this cycle.
- InReady  output  1  buffer can accept an entry this cycle.
- Instruction  input  32  fetched instruction word.
- NextInstruct  input  32  PC+4 of the fetched instruction.
- Flush  input  1  discard all held entries (branch/jump taken).
- OutValid  output  1  head entry is valid.
- OutReady  input  1  decode consumes the head entry this cycle.
- OutInstruction  output  32  head instruction, or NOP_WORD when empty.
- OutNextInstruct  output  32  head PC+4, or 0 when empty.
- Count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH entries {instruction, pc+4}, with read pointer, write pointer and occupancy count. Pointers wrap modulo DEPTH.
- Reset (synchronous, Reset=1 at a rising edge):
  - Count=0, both pointers=0, all storage cleared to 0.
  - OutValid=0, OutInstruction=NOP_WORD, OutNextInstruct=0, InReady=1.
  - Reset overrides Flush and all handshakes, including when asserted mid-operation.
- InReady = (Count != DEPTH). It depends only on registered state; there is no combinational path from OutReady.
- OutValid = (Count != 0). Outputs are driven directly from the head storage entry, muxed to NOP/0 when empty.
- Push = InValid & InReady. At the edge the entry is written at the write pointer and the write pointer increments.
- Pop = OutValid & OutReady. At the edge the read pointer increments.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (one-cycle latency). There is no same-cycle bypass from input to output.
- Full (Count=DEPTH): InReady=0. A pop in that cycle frees a slot, but InReady rises only in the following cycle.
- Empty (Count=0): a pop request is ignored and OutValid stays 0.
- Flush=1 at an edge (Reset=0):
  - Count=0; read pointer is set equal to the write pointer.
  - A push or pop in the same cycle is discarded, so the instruction on Instruction that cycle is dropped.
  - OutValid=0 after the edge.
  - Storage contents need not be cleared.
- Flush priority: Reset > Flush > push/pop.
- Throughput: one instruction per cycle is sustained whenever OutReady=1.
- Ordering: strict FIFO; no reordering or duplication.

Decomposition:
- Shared package:
  - INSTR_W=32 and NOP_WORD constant.
  - A packed struct type for a fetch entry {instr[31:0], pc4[31:0]}, reused by the future ID/EX register.
- Sub-module ring_store: DEPTH x 64-bit register array with synchronous write, asynchronous read and synchronous clear. Pointer, count and handshake logic stay in fetch_decode_buffer.

Test Plan:
1. Reset, then hold InValid=0 for 3 cycles -> OutValid=0, OutInstruction=32'h0, InReady=1, Count=0.
2. Push 0x20080005/pc4 0x4 and then 0x21290001/pc4 0x8 on consecutive cycles with OutReady=0 -> Count=2, InReady=0, head=0x20080005. Then OutReady=1 for 2 cycles -> the two entries emerge in order, then OutValid=0.
3. Streaming with InValid=1 and OutReady=1 on every cycle for 8 words 0x1..0x8 -> each word appears exactly one cycle after its push; Count stays at 1; no bubbles.
4. Buffer full (DEPTH=2), with Flush=1 and InValid=1 (word 0xDEAD) in the same cycle -> next cycle Count=0 and OutValid=0; 0xDEAD is never output; the next push 0x08000010 appears as head.
5. Pointer wrap: 5 push/pop rounds of alternating occupancy 2 and 0 -> output order matches input order across the pointer wrap from 1 to 0.
6. Reset asserted while Count=1 and Flush=1 -> Count=0, outputs at reset values, InReady=1 next cycle.
